data_memory_arbiter: RTL and testbench

Shares the single-port data memory between the general-purpose processor (GPP) datapath and the communications processor (CP). Each cycle it grants one requester and steers address, write data and write enable to the memory. It stalls the GPP while the CP owns the port. A wait counter and a bounded burst lock keep either side from starving the other.

---
 rtl/data_memory_arbiter.sv | 111 +++++++++++
 tb/tb_data_memory_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Single-port data memory arbiter between the GPP datapath and the communications processor.
// Combinational grant/steering; registered fairness state (wait counter, bounded CP burst lock).
module data_memory_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gpp_req,
    input  logic                  gpp_we,
    input  logic [ADDR_WIDTH-1:0] gpp_address,
    input  logic [DATA_WIDTH-1:0] gpp_wdata,
    output logic [DATA_WIDTH-1:0] gpp_rdata,
    output logic                  gpp_stall,
    input  logic                  cp_req,
    input  logic                  cp_we,
    input  logic                  cp_lock,
    input  logic [ADDR_WIDTH-1:0] cp_address,
    input  logic [DATA_WIDTH-1:0] cp_wdata,
    output logic [DATA_WIDTH-1:0] cp_rdata,
    output logic                  cp_grant,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic {
        ARB,
        CP_BURST
    } state_t;

    localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
    localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

    state_t     state_q, state_d;
    logic [3:0] wait_count_q, wait_count_d;
    logic [7:0] burst_count_q, burst_count_d;

    logic       gpp_grant;
    logic       cp_grant_int;
    logic       cp_wins_arb;
    logic       burst_hold;
    logic       burst_full;
    logic [7:0] burst_next;

    always_comb begin
        cp_grant_int  = 1'b0;
        gpp_grant     = 1'b0;
        state_d       = state_q;
        wait_count_d  = wait_count_q;
        burst_count_d = burst_count_q;
        burst_next    = burst_count_q + 8'd1;
        burst_full    = 1'b0;

        // A burst cycle without a CP request falls back to normal arbitration.
        burst_hold  = (state_q == CP_BURST) && cp_req;
        cp_wins_arb = cp_req && (!gpp_req || (wait_count_q == MAX_WAIT_C));

        if (!rst) begin
            cp_grant_int = burst_hold || cp_wins_arb;
            gpp_grant    = gpp_req && !cp_grant_int;
        end

        if (state_q == CP_BURST) begin
            if (cp_req) begin
                burst_count_d = burst_next;
                burst_full    = (burst_next == BURST_MAX_C);
                if (!cp_lock || burst_full) begin
                    state_d       = ARB;
                    burst_count_d = 8'd0;
                end
            end else begin
                state_d       = ARB;
                burst_count_d = 8'd0;
            end
        end else if (cp_grant_int && cp_lock) begin
            state_d       = CP_BURST;
            burst_count_d = 8'd1;
        end

        if (cp_req && !cp_grant_int && !burst_full) begin
            wait_count_d = (wait_count_q == MAX_WAIT_C) ? wait_count_q : wait_count_q + 4'd1;
        end else begin
            wait_count_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB;
            wait_count_q  <= 4'd0;
            burst_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            wait_count_q  <= wait_count_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign cp_grant         = cp_grant_int;
    assign gpp_stall        = gpp_req && !gpp_grant && !rst;
    assign mem_address      = cp_grant_int ? cp_address : gpp_address;
    assign mem_data_in      = cp_grant_int ? cp_wdata : gpp_wdata;
    assign mem_write_enable = cp_grant_int ? cp_we : (gpp_we && gpp_grant);
    assign gpp_rdata        = mem_data_out;
    assign cp_rdata         = mem_data_out;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural arbitration/memory model.
module tb_data_memory_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int MW = 4;
    localparam int BM = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gpp_req = 1'b0, gpp_we = 1'b0;
    logic [AW-1:0] gpp_address = '0;
    logic [DW-1:0] gpp_wdata = '0;
    logic [DW-1:0] gpp_rdata;
    logic          gpp_stall;
    logic          cp_req = 1'b0, cp_we = 1'b0, cp_lock = 1'b0;
    logic [AW-1:0] cp_address = '0;
    logic [DW-1:0] cp_wdata = '0;
    logic [DW-1:0] cp_rdata;
    logic          cp_grant;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_write_enable;
    logic [DW-1:0] mem_data_out;

    always #5 clk = ~clk;

    data_memory_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .rst(rst),
        .gpp_req(gpp_req), .gpp_we(gpp_we), .gpp_address(gpp_address),
        .gpp_wdata(gpp_wdata), .gpp_rdata(gpp_rdata), .gpp_stall(gpp_stall),
        .cp_req(cp_req), .cp_we(cp_we), .cp_lock(cp_lock), .cp_address(cp_address),
        .cp_wdata(cp_wdata), .cp_rdata(cp_rdata), .cp_grant(cp_grant),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
    );

    // Memory attached to the DUT: asynchronous read, write on rising edge.
    logic [DW-1:0] mem [256];
    logic          mem_clr = 1'b1;
    assign mem_data_out = mem[mem_address[7:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_write_enable) begin
            mem[mem_address[7:0]] <= mem_data_in;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: fairness counters and a shadow memory.
    logic [DW-1:0] ref_mem [256];
    int            m_wait  = 0;
    bit            m_burst = 1'b0;
    int            m_blen  = 0;
    int            cyc     = 0;

    always @(negedge clk) begin
        bit            e_cp, e_gpp, e_we, arb_cp;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [7:0]    idx;
        cyc++;
        if (mem_clr) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        if (rst) begin
            e_cp  = 1'b0;
            e_gpp = 1'b0;
        end else begin
            arb_cp = cp_req && (!gpp_req || m_wait >= MW);
            e_cp   = cp_req && (m_burst || arb_cp);
            e_gpp  = gpp_req && !e_cp;
        end
        e_addr = e_cp ? cp_address : gpp_address;
        e_wd   = e_cp ? cp_wdata : gpp_wdata;
        e_we   = e_cp ? cp_we : (e_gpp && gpp_we);
        idx    = e_addr[7:0];

        check("cp_grant", {31'd0, cp_grant}, {31'd0, e_cp});
        check("gpp_stall", {31'd0, gpp_stall}, {31'd0, gpp_req && !e_gpp && !rst});
        check("mem_we", {31'd0, mem_write_enable}, {31'd0, e_we});
        check("mem_addr", {16'd0, mem_address}, {16'd0, e_addr});
        if (e_we) check("mem_wdata", {16'd0, mem_data_in}, {16'd0, e_wd});
        if (e_cp && !cp_we) check("cp_rdata", {16'd0, cp_rdata}, {16'd0, ref_mem[idx]});
        if (e_gpp && !gpp_we) check("gpp_rdata", {16'd0, gpp_rdata}, {16'd0, ref_mem[idx]});

        if (e_cp || e_gpp)
            $display("[%0d] %s %s addr=%h data=%h", cyc, e_cp ? "CP " : "GPP",
                     e_we ? "WR" : "RD", e_addr, e_we ? e_wd : ref_mem[idx]);

        if (e_we) ref_mem[idx] = e_wd;
        if (rst) begin
            m_wait  = 0;
            m_burst = 1'b0;
            m_blen  = 0;
        end else if (e_cp) begin
            m_wait  = 0;
            m_blen  = m_burst ? m_blen + 1 : (cp_lock ? 1 : 0);
            m_burst = cp_lock && m_blen > 0 && m_blen < BM;
        end else begin
            m_burst = 1'b0;
            m_blen  = 0;
            m_wait  = cp_req ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1; gpp_req = 1'b0; cp_req = 1'b0; cp_lock = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic contend(input logic lock, input logic we);
        gpp_req = 1'b1; gpp_we = 1'b0; gpp_address = 16'h0021;
        cp_req = 1'b1; cp_we = we; cp_lock = lock; cp_address = 16'h0032; cp_wdata = 16'hbeef;
    endtask

    logic [9:0]  pat_fair  = 10'b0000100001;
    logic [19:0] pat_burst = 20'b0000_1111_1111_0000_1111;

    initial begin
        // Reset cycle with every request active.
        gpp_req = 1'b1; gpp_we = 1'b1; gpp_address = 16'h0abc;
        cp_req = 1'b1; cp_we = 1'b1; cp_lock = 1'b1; cp_address = 16'h0055;
        @(negedge clk);
        check("rst_cp_grant", {31'd0, cp_grant}, 32'd0);
        check("rst_stall", {31'd0, gpp_stall}, 32'd0);
        check("rst_we", {31'd0, mem_write_enable}, 32'd0);
        check("rst_addr", {16'd0, mem_address}, 32'h0abc);
        next_cycle();
        rst = 1'b0; mem_clr = 1'b0; cp_req = 1'b0; cp_lock = 1'b0; cp_we = 1'b0;

        // GPP write then read back.
        gpp_req = 1'b1; gpp_we = 1'b1; gpp_address = 16'h0010; gpp_wdata = 16'h1234;
        @(negedge clk);
        check("t1_we", {31'd0, mem_write_enable}, 32'd1);
        check("t1_wdata", {16'd0, mem_data_in}, 32'h1234);
        next_cycle();
        gpp_we = 1'b0;
        @(negedge clk);
        check("t1_rdata", {16'd0, gpp_rdata}, 32'h1234);
        check("t1_stall", {31'd0, gpp_stall}, 32'd0);
        check("t1_cp_grant", {31'd0, cp_grant}, 32'd0);
        next_cycle();

        // Continuous contention without lock: CP gets every fifth cycle.
        contend(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("fair_cp_grant", {31'd0, cp_grant}, {31'd0, pat_fair[9-i]});
            check("fair_stall", {31'd0, gpp_stall}, {31'd0, pat_fair[9-i]});
            next_cycle();
        end

        // Locked bursts bounded at BURST_MAX grants.
        reset_pulse();
        contend(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("burst_cp_grant", {31'd0, cp_grant}, {31'd0, pat_burst[19-i]});
            next_cycle();
        end

        // CP drops its lock after three burst grants.
        reset_pulse();
        contend(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) next_cycle();
        cp_lock = 1'b0;
        next_cycle();
        @(negedge clk);
        check("unlock_cp_grant", {31'd0, cp_grant}, 32'd0);
        check("unlock_stall", {31'd0, gpp_stall}, 32'd0);
        next_cycle();

        // Reset in the fourth burst cycle while the CP is writing.
        reset_pulse();
        contend(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_we", {31'd0, mem_write_enable}, 32'd0);
        check("midrst_cp_grant", {31'd0, cp_grant}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_cp_grant", {31'd0, cp_grant}, 32'd0);
        check("postrst_stall", {31'd0, gpp_stall}, 32'd0);
        next_cycle();

        // Idle.
        gpp_req = 1'b0; cp_req = 1'b0; cp_lock = 1'b0; gpp_we = 1'b1; cp_we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_we", {31'd0, mem_write_enable}, 32'd0);
            check("idle_cp_grant", {31'd0, cp_grant}, 32'd0);
            check("idle_stall", {31'd0, gpp_stall}, 32'd0);
            next_cycle();
        end

        // Randomized traffic; the per-cycle model does the checking.
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            gpp_req     = ($urandom_range(0, 3) != 0);
            gpp_we      = $urandom_range(0, 1) == 1;
            gpp_address = 16'($urandom_range(0, 15));
            gpp_wdata   = 16'($urandom);
            cp_req      = $urandom_range(0, 1) == 1;
            cp_we       = $urandom_range(0, 1) == 1;
            cp_lock     = ($urandom_range(0, 2) != 0);
            cp_address  = 16'($urandom_range(0, 15));
            cp_wdata    = 16'($urandom);
            next_cycle();
        end
        rst = 1'b0; gpp_req = 1'b0; cp_req = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
